// File: rtl/alu_seq_pkg.sv
// Shared types and constants for the ALU instruction sequencer: control-step
// states, opcode values, one-hot ALU strobe positions and IR field layout.
package alu_seq_pkg;

    // Control steps; T6 is reached only when SEQ_MULDIV_EN is defined
    typedef enum logic [3:0] {
        StIdle, StT0, StT1, StT2, StT3, StT4, StT5, StT6, StIll
    } state_e;

    // Execute-phase shape of an opcode
    typedef enum logic [1:0] {
        ClsBinary, ClsUnary, ClsMulDiv, ClsIllegal
    } op_class_e;

    // Opcode field values
    localparam logic [4:0] OpAdd  = 5'h03;
    localparam logic [4:0] OpSub  = 5'h04;
    localparam logic [4:0] OpShr  = 5'h05;
    localparam logic [4:0] OpShra = 5'h06;
    localparam logic [4:0] OpShl  = 5'h07;
    localparam logic [4:0] OpRor  = 5'h08;
    localparam logic [4:0] OpRol  = 5'h09;
    localparam logic [4:0] OpAnd  = 5'h0A;
    localparam logic [4:0] OpOr   = 5'h0B;
    localparam logic [4:0] OpMul  = 5'h0F;
    localparam logic [4:0] OpDiv  = 5'h10;
    localparam logic [4:0] OpNeg  = 5'h11;
    localparam logic [4:0] OpNot  = 5'h12;

    // Bit positions inside the one-hot alu_op vector
    localparam int unsigned AluAdd  = 0;
    localparam int unsigned AluSub  = 1;
    localparam int unsigned AluShr  = 2;
    localparam int unsigned AluShra = 3;
    localparam int unsigned AluShl  = 4;
    localparam int unsigned AluRor  = 5;
    localparam int unsigned AluRol  = 6;
    localparam int unsigned AluAnd  = 7;
    localparam int unsigned AluOr   = 8;
    localparam int unsigned AluMul  = 9;
    localparam int unsigned AluDiv  = 10;
    localparam int unsigned AluNeg  = 11;
    localparam int unsigned AluNot  = 12;

    // IR field layout (fields are read LSB-first with the configured index width)
    localparam int unsigned OpLsb = 27;
    localparam int unsigned RaLsb = 23;
    localparam int unsigned RbLsb = 19;
    localparam int unsigned RcLsb = 15;

endpackage

// File: rtl/seq_opcode_decode.sv
// Combinational opcode decoder: maps the 5-bit op field to its execute class
// and the matching one-hot ALU strobe. Honours macro SEQ_MULDIV_EN: when it is
// undefined, MUL and DIV decode as illegal.
module seq_opcode_decode
    import alu_seq_pkg::*;
#(
    parameter int unsigned NOPS = 13
) (
    input  logic [4:0]      op,
    output op_class_e       op_class,
    output logic [NOPS-1:0] alu_op
);

    // Table lookup; unlisted opcodes are illegal with no ALU strobe
    always_comb begin
        op_class = ClsIllegal;
        alu_op   = '0;
        case (op)
            OpAdd:  begin op_class = ClsBinary; alu_op[AluAdd]  = 1'b1; end
            OpSub:  begin op_class = ClsBinary; alu_op[AluSub]  = 1'b1; end
            OpShr:  begin op_class = ClsBinary; alu_op[AluShr]  = 1'b1; end
            OpShra: begin op_class = ClsBinary; alu_op[AluShra] = 1'b1; end
            OpShl:  begin op_class = ClsBinary; alu_op[AluShl]  = 1'b1; end
            OpRor:  begin op_class = ClsBinary; alu_op[AluRor]  = 1'b1; end
            OpRol:  begin op_class = ClsBinary; alu_op[AluRol]  = 1'b1; end
            OpAnd:  begin op_class = ClsBinary; alu_op[AluAnd]  = 1'b1; end
            OpOr:   begin op_class = ClsBinary; alu_op[AluOr]   = 1'b1; end
            OpNeg:  begin op_class = ClsUnary;  alu_op[AluNeg]  = 1'b1; end
            OpNot:  begin op_class = ClsUnary;  alu_op[AluNot]  = 1'b1; end
`ifdef SEQ_MULDIV_EN
            OpMul:  begin op_class = ClsMulDiv; alu_op[AluMul]  = 1'b1; end
            OpDiv:  begin op_class = ClsMulDiv; alu_op[AluDiv]  = 1'b1; end
`else
            OpMul, OpDiv: begin op_class = ClsIllegal; alu_op = '0; end
`endif
            default: begin op_class = ClsIllegal; alu_op = '0; end
        endcase
    end

endmodule

// File: rtl/alu_instr_sequencer.sv
// Hardwired control-step generator for register-register ALU instructions.
// Runs fetch (T0-T2) then execute (T3-T6) and drives the DataPath strobes as
// Moore outputs of the registered step. Macro SEQ_MULDIV_EN enables MUL/DIV
// (T6, HIin/LOin/Zhighout); without it those opcodes trap to the illegal step.
module alu_instr_sequencer
    import alu_seq_pkg::*;
#(
    parameter int unsigned NREGS = 16,
    parameter int unsigned IDX_W = 4,
    parameter int unsigned NOPS  = 13
) (
    input  logic             Clock,
    input  logic             Clear,
    input  logic             start,
    input  logic             mem_ready,
    input  logic [31:0]      ir,
    output logic             busy,
    output logic             done,
    output logic             illegal,
    output logic             PCout,
    output logic             MARin,
    output logic             IncPC,
    output logic             Zin,
    output logic             Zlowout,
    output logic             Zhighout,
    output logic             PCin,
    output logic             Read,
    output logic             MDRin,
    output logic             MDRout,
    output logic             IRin,
    output logic             Yin,
    output logic             HIin,
    output logic             LOin,
    output logic [NREGS-1:0] reg_in,
    output logic [NREGS-1:0] reg_out,
    output logic [NOPS-1:0]  alu_op
);

    localparam logic [NREGS-1:0] OneReg = NREGS'(1);

    state_e            state_q, state_d;
    op_class_e         op_class;
    logic [NOPS-1:0]   dec_alu;
    logic [IDX_W-1:0]  ra, rb, rc;
    logic              ra_bad, rb_bad, rc_bad, idx_bad, ill;
    logic              unused_ir;

    assign ra = ir[RaLsb +: IDX_W];
    assign rb = ir[RbLsb +: IDX_W];
    assign rc = ir[RcLsb +: IDX_W];
    assign unused_ir = ^ir[14:0];

    seq_opcode_decode #(
        .NOPS (NOPS)
    ) u_decode (
        .op       (ir[OpLsb +: 5]),
        .op_class (op_class),
        .alu_op   (dec_alu)
    );

    // Only the indices an instruction class actually reads may trap
    assign ra_bad  = int'(ra) >= NREGS;
    assign rb_bad  = int'(rb) >= NREGS;
    assign rc_bad  = int'(rc) >= NREGS;
    assign idx_bad = ((op_class == ClsBinary) && (ra_bad || rb_bad || rc_bad)) ||
                     ((op_class == ClsUnary)  && (ra_bad || rb_bad)) ||
                     ((op_class == ClsMulDiv) && (rb_bad || rc_bad));
    assign ill     = (op_class == ClsIllegal) || idx_bad;

    // Step register; Clear aborts immediately so no later strobe can fire
    always_ff @(posedge Clock or posedge Clear) begin
        if (Clear) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    // Next step and Moore strobe decode for the current step
    always_comb begin
        state_d  = state_q;
        busy     = (state_q != StIdle);
        done     = 1'b0;
        illegal  = 1'b0;
        PCout    = 1'b0;
        MARin    = 1'b0;
        IncPC    = 1'b0;
        Zin      = 1'b0;
        Zlowout  = 1'b0;
        Zhighout = 1'b0;
        PCin     = 1'b0;
        Read     = 1'b0;
        MDRin    = 1'b0;
        MDRout   = 1'b0;
        IRin     = 1'b0;
        Yin      = 1'b0;
        HIin     = 1'b0;
        LOin     = 1'b0;
        reg_in   = '0;
        reg_out  = '0;
        alu_op   = '0;
        unique case (state_q)
            StIdle: begin
                if (start) state_d = StT0;
            end
            StT0: begin
                PCout   = 1'b1;
                MARin   = 1'b1;
                IncPC   = 1'b1;
                Zin     = 1'b1;
                state_d = StT1;
            end
            StT1: begin
                // PC reload repeats while waiting; Z still holds PC+1
                Zlowout = 1'b1;
                PCin    = 1'b1;
                Read    = 1'b1;
                MDRin   = 1'b1;
                if (mem_ready) state_d = StT2;
            end
            StT2: begin
                MDRout  = 1'b1;
                IRin    = 1'b1;
                state_d = StT3;
            end
            StT3: begin
                if (ill) begin
                    state_d = StIll;
                end else begin
                    reg_out = OneReg << rb;
                    if (op_class == ClsUnary) begin
                        alu_op = dec_alu;
                        Zin    = 1'b1;
                    end else begin
                        Yin = 1'b1;
                    end
                    state_d = StT4;
                end
            end
            StT4: begin
                if (op_class == ClsUnary) begin
                    Zlowout = 1'b1;
                    reg_in  = OneReg << ra;
                    done    = 1'b1;
                    state_d = StIdle;
                end else begin
                    reg_out = OneReg << rc;
                    alu_op  = dec_alu;
                    Zin     = 1'b1;
                    state_d = StT5;
                end
            end
            StT5: begin
                Zlowout = 1'b1;
`ifdef SEQ_MULDIV_EN
                if (op_class == ClsMulDiv) begin
                    LOin    = 1'b1;
                    state_d = StT6;
                end else begin
                    reg_in  = OneReg << ra;
                    done    = 1'b1;
                    state_d = StIdle;
                end
`else
                reg_in  = OneReg << ra;
                done    = 1'b1;
                state_d = StIdle;
`endif
            end
`ifdef SEQ_MULDIV_EN
            StT6: begin
                Zhighout = 1'b1;
                HIin     = 1'b1;
                done     = 1'b1;
                state_d  = StIdle;
            end
`endif
            StIll: begin
                illegal = 1'b1;
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

endmodule
